// File: rtl/melody_sequencer.sv
// Melody sequencer: plays up to eight stored note entries, each held for
// dur * TICK_DIV clock cycles, with optional looping and a stop abort.
module melody_sequencer #(
   parameter int TICK_DIV = 1000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       wr_en,
   input  logic [2:0] wr_addr,
   input  logic [7:0] wr_data,
   input  logic [3:0] len,
   input  logic       loop,
   input  logic       start,
   input  logic       stop,
   output logic       Tom,
   output logic       notas1,
   output logic       notas2,
   output logic       notas3,
   output logic       nota_valida,
   output logic [2:0] idx,
   output logic       busy,
   output logic       done
);

   localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [TW-1:0] TICK_MAX = TW'(TICK_DIV - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_FETCH,
      S_PLAY,
      S_DONE
   } state_t;

   state_t        state_q, state_d;
   logic [7:0]    mem_q [8];
   logic [7:0]    mem_d [8];
   logic [3:0]    len_q, len_d;
   logic [3:0]    unit_q, unit_d;
   logic [TW-1:0] tick_q, tick_d;
   logic [2:0]    idx_q, idx_d;
   logic          tom_q, tom_d;
   logic [2:0]    notas_q, notas_d;
   logic          tom_o_q, tom_o_d;
   logic [2:0]    notas_o_q, notas_o_d;
   logic          nv_q, nv_d;

   logic [7:0]    entry;
   logic          last_idx;
   logic [2:0]    adv_idx;
   state_t        adv_state;

   always_comb begin
      mem_d = mem_q;
      if (wr_en) begin
         mem_d[wr_addr] = wr_data;
      end
   end

   // Where to go once the current entry is finished or skipped.
   always_comb begin
      entry     = mem_q[idx_q];
      last_idx  = ({1'b0, idx_q} == (len_q - 4'd1));
      adv_idx   = idx_q + 3'd1;
      adv_state = S_FETCH;
      if (last_idx) begin
         if (loop) begin
            adv_idx = 3'd0;
         end else begin
            adv_idx   = idx_q;
            adv_state = S_DONE;
         end
      end
   end

   always_comb begin
      state_d = state_q;
      len_d   = len_q;
      unit_d  = unit_q;
      tick_d  = tick_q;
      idx_d   = idx_q;
      tom_d   = tom_q;
      notas_d = notas_q;
      unique case (state_q)
         S_IDLE: begin
            if (start && !stop && (len != 4'd0)) begin
               len_d   = (len > 4'd8) ? 4'd8 : len;
               idx_d   = 3'd0;
               state_d = S_FETCH;
            end
         end
         S_FETCH: begin
            tom_d   = entry[7];
            notas_d = entry[6:4];
            unit_d  = entry[3:0];
            tick_d  = TICK_MAX;
            if (entry[3:0] != 4'd0) begin
               state_d = S_PLAY;
            end else begin
               state_d = adv_state;
               idx_d   = adv_idx;
            end
         end
         S_PLAY: begin
            if (tick_q == '0) begin
               if (unit_q == 4'd1) begin
                  state_d = adv_state;
                  idx_d   = adv_idx;
               end else begin
                  unit_d = unit_q - 4'd1;
                  tick_d = TICK_MAX;
               end
            end else begin
               tick_d = tick_q - TW'(1);
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
      if (stop && (state_q != S_IDLE)) begin
         state_d = S_IDLE;
      end
      // Note outputs are only ever non-zero while sounding.
      nv_d      = (state_d == S_PLAY);
      tom_o_d   = nv_d ? tom_d : 1'b0;
      notas_o_d = nv_d ? notas_d : 3'b000;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= S_IDLE;
         len_q     <= '0;
         unit_q    <= '0;
         tick_q    <= '0;
         idx_q     <= '0;
         tom_q     <= 1'b0;
         notas_q   <= '0;
         tom_o_q   <= 1'b0;
         notas_o_q <= '0;
         nv_q      <= 1'b0;
         for (int i = 0; i < 8; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         state_q   <= state_d;
         len_q     <= len_d;
         unit_q    <= unit_d;
         tick_q    <= tick_d;
         idx_q     <= idx_d;
         tom_q     <= tom_d;
         notas_q   <= notas_d;
         tom_o_q   <= tom_o_d;
         notas_o_q <= notas_o_d;
         nv_q      <= nv_d;
         mem_q     <= mem_d;
      end
   end

   assign Tom         = tom_o_q;
   assign notas1      = notas_o_q[0];
   assign notas2      = notas_o_q[1];
   assign notas3      = notas_o_q[2];
   assign nota_valida = nv_q;
   assign idx         = idx_q;
   assign busy        = (state_q != S_IDLE);
   assign done        = (state_q == S_DONE);

endmodule

// File: doc/melody_sequencer.md
MELODY_SEQUENCER -- requirements
Module: melody_sequencer

Interface
REQ-001 The block SHALL have a single clock and an asynchronous, active-high reset.
REQ-002 Parameter: TICK_DIV, default 1000, clock cycles per duration unit (legal range >= 1).
REQ-003 clk  input  1  rising-edge clock.
REQ-004 rst  input  1  asynchronous active-high reset.
REQ-005 wr_en  input  1  note-memory write strobe.
REQ-006 wr_addr  input  3  note-memory entry index.
REQ-007 wr_data  input  8  entry: [7]=Tom, [6:4]={notas3,notas2,notas1}, [3:0]=dur (units).
REQ-008 len  input  4  number of entries to play; sampled at start.
REQ-009 loop  input  1  repeat the sequence at its end; sampled at each wrap.
REQ-010 start  input  1  begin playback (single-cycle pulse).
REQ-011 stop  input  1  abort playback (single-cycle pulse).
REQ-012 Tom, notas1, notas2, notas3  output  1 each  registered note code to the note-display decoder.
REQ-013 nota_valida  output  1  high while a note is sounding.
REQ-014 idx  output  3  entry currently fetched or playing.
REQ-015 busy  output  1  high in any state other than IDLE.
REQ-016 done  output  1  one-cycle pulse at non-looping end of sequence.

Function
REQ-017 The memory SHALL be 8x8 registers; a write with wr_en high SHALL land on the clock edge in any state.
REQ-018 A write to the entry currently playing SHALL NOT alter the current note, because entry fields latch in FETCH.
REQ-019 The FSM states SHALL be IDLE, FETCH, PLAY and DONE.
REQ-020 IDLE: start with len != 0 SHALL latch len_q = min(len, 8), set idx = 0 and go to FETCH.
REQ-021 IDLE: start with len = 0 SHALL be ignored.
REQ-022 FETCH (one cycle, nota_valida = 0): the FSM SHALL latch Tom/notas/dur from mem[idx].
REQ-023 FETCH: if dur != 0, the FSM SHALL go to PLAY, load the unit counter with dur and the tick counter with TICK_DIV-1.
REQ-024 FETCH: if dur = 0, the entry SHALL be skipped via the advance rule, producing no output.
REQ-025 PLAY SHALL last exactly dur*TICK_DIV cycles with nota_valida = 1 and Tom/notas3..1 equal to the latched entry.
REQ-026 PLAY: tick counter decrements each cycle; at 0 it reloads to TICK_DIV-1 and the unit counter decrements; the last tick of the last unit SHALL trigger advance.
REQ-027 Advance, idx < len_q-1: idx+1, go to FETCH.
REQ-028 Advance, idx = len_q-1 with loop = 1: idx = 0, go to FETCH.
REQ-029 Advance, idx = len_q-1 with loop = 0: go to DONE.
REQ-030 DONE SHALL last one cycle with done = 1, then go to IDLE.
REQ-031 Tom, notas3..1 and nota_valida SHALL be 0 in every state except PLAY.
REQ-032 stop in any non-IDLE state SHALL force IDLE on the next edge with outputs cleared and no done pulse.
REQ-033 stop SHALL take priority over start and over note-end advance.
REQ-034 start while busy SHALL be ignored.
REQ-035 With every entry dur = 0 and loop = 1, the FSM SHALL cycle FETCH only, with busy = 1 and nota_valida = 0, until stop.

Reset
REQ-036 rst SHALL asynchronously force state IDLE and idx = 0.
REQ-037 rst SHALL clear all counters, all outputs and all memory entries to 0.
REQ-038 rst asserted mid-PLAY SHALL drop nota_valida and busy immediately, without waiting for a clock edge.

Verification (TICK_DIV = 4)
REQ-039 Two-note sequence: mem0 = 0x92, mem1 = 0x31, len = 2, loop = 0, start -> 1 FETCH cycle; 8 cycles of Tom=1, notas=001, nota_valida=1; 1 gap cycle; 4 cycles of Tom=0, notas=011; done pulse for 1 cycle; busy low afterwards.
REQ-040 Skip: mem0 = 0x90, mem1 = 0x21, len = 2 -> 2 FETCH cycles (idx 0 then 1), then 4 cycles of notas=010; no output ever shows entry 0.
REQ-041 Loop: len = 1, loop = 1, mem0 = 0x11 -> repeating pattern of 4 PLAY cycles plus 1 FETCH cycle, idx stays 0, no done; deassert loop -> done after the current note.
REQ-042 Stop and ignore: stop at the 3rd PLAY cycle -> next cycle busy = 0, nota_valida = 0, done = 0; start with len = 0 -> busy stays 0; start while busy -> idx sequence unchanged.
REQ-043 Clamp: len = 12 -> idx runs 0..7 only.
REQ-044 Reset and write-during-play: rst asserted mid-note -> all outputs 0 immediately and a following start with len = 1 plays 0x00 (dur 0, skipped) then done; writing mem0 while entry 0 plays -> current note unchanged, new value heard on the next loop pass.
